// File: rtl/dmem_req_stage_pkg.sv
// Shared types for the data-memory request stage: access widths, FSM states and
// the slice of execute-stage state the stage consumes.
package dmem_req_stage_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } dmem_fsm_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic        mem_read;
    logic        mem_write;
    mem_width_t  mem_width;
  } exec_state_t;

endpackage

// File: rtl/dmem_req_stage_store_align.sv
// dmem_store_align: byte enables and lane-replicated store data for a sub-word access
// at byte offset off_i within the addressed word.
module dmem_store_align
  import dmem_req_stage_pkg::*;
(
  input  mem_width_t  width_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    case (width_i)
      BYTE:    be_o = 4'b0001 << off_i;
      HALF:    be_o = 4'b0011 << off_i;
      default: be_o = 4'b1111;
    endcase
  end

  // Replicating the narrow datum into every lane lets the enables alone pick the target bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_o[8*gi +: 8] = (width_i == BYTE) ? wdata_i[7:0] :
                                (width_i == HALF) ? wdata_i[8*(gi%2) +: 8] :
                                                    wdata_i[8*gi +: 8];
  end

endmodule

// File: rtl/dmem_req_stage.sv
// dmem_req_stage: single-outstanding data-memory request stage with a watchdog abort.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned HALF/WORD accesses instead of truncating the offset.
module dmem_req_stage
  import dmem_req_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  exec_state_t exec_state_i,
  input  logic [31:0] wdata_i,
  input  logic        squash_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic        dmem_err_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam int unsigned      CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  dmem_fsm_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             squash_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;

  logic [1:0]  off;
  logic [1:0]  eff_off;
  logic        is_mem;
  logic        access;
  logic        complete;
  logic        timeout;
  logic        killed;
  logic [31:0] addr_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign off    = exec_state_i.alu_out[1:0];
  assign is_mem = exec_state_i.mem_read | exec_state_i.mem_write;
  assign addr_c = {exec_state_i.alu_out[31:2], 2'b00};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_o = ((exec_state_i.mem_width == HALF) & off[0]) |
                      ((exec_state_i.mem_width == WORD) & (off != 2'b00));
  assign eff_off    = off;
`else
  assign misalign_o = 1'b0;
  assign eff_off    = (exec_state_i.mem_width == BYTE)            ? off :
                      ((exec_state_i.mem_width == HALF) & ~off[0]) ? off : 2'b00;
`endif

  assign access = valid_i & is_mem & ~squash_i & ~misalign_o;

  dmem_store_align u_align (
    .width_i (exec_state_i.mem_width),
    .off_i   (eff_off),
    .wdata_i (wdata_i),
    .be_o    (be_c),
    .wdata_o (wdata_c)
  );

  // IDLE drives the bus straight from execute so a ready slave can finish in one cycle.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = we_q;
    dmem_addr_o  = addr_q;
    dmem_be_o    = be_q;
    dmem_wdata_o = wdata_q;
    complete     = 1'b0;
    timeout      = 1'b0;
    stall_o      = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req_o   = access;
        dmem_we_o    = access & exec_state_i.mem_write;
        dmem_addr_o  = access ? addr_c  : '0;
        dmem_be_o    = access ? be_c    : '0;
        dmem_wdata_o = access ? wdata_c : '0;
        complete     = access & dmem_gnt_i & dmem_rvalid_i;
        stall_o      = access & ~complete;
      end
      REQ: begin
        timeout    = (cnt_q == CNT_LAST);
        dmem_req_o = ~timeout;
        complete   = ~timeout & dmem_gnt_i & dmem_rvalid_i;
        stall_o    = ~timeout & ~complete;
      end
      WAIT: begin
        complete = dmem_rvalid_i;
        timeout  = (cnt_q == CNT_LAST) & ~dmem_rvalid_i;
        stall_o  = ~complete & ~timeout;
      end
      default: dmem_req_o = 1'b0;
    endcase
  end

  // A squash after issue only silences the completion; the bus handshake still finishes.
  assign killed    = (state_q != IDLE) & (squash_q | squash_i);
  assign done_o    = complete & ~killed;
  assign bus_err_o = ((complete & dmem_err_i) | timeout) & ~killed;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      squash_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          squash_q <= 1'b0;
          if (access && !complete) begin
            state_q <= dmem_gnt_i ? WAIT : REQ;
            we_q    <= exec_state_i.mem_write;
            addr_q  <= addr_c;
            be_q    <= be_c;
            wdata_q <= wdata_c;
          end
        end
        REQ: begin
          cnt_q    <= cnt_q + CNT_W'(1);
          squash_q <= squash_q | squash_i;
          if (timeout) begin
            state_q <= IDLE;
          end else if (dmem_gnt_i) begin
            state_q <= dmem_rvalid_i ? IDLE : WAIT;
          end
        end
        WAIT: begin
          cnt_q    <= cnt_q + CNT_W'(1);
          squash_q <= squash_q | squash_i;
          if (complete || timeout) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_req_stage.sv
// Self-checking bench for dmem_req_stage: directed scenarios plus randomized
// transactions scored against a cycle-count reference model.
module tb_dmem_req_stage;
  import dmem_req_stage_pkg::*;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  exec_state_t es = '0;
  logic [31:0] wdata = '0;
  logic        squash = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic        err = 1'b0;
  logic        req, we, stall, done, berr, misalign;
  logic [31:0] addr, bwdata;
  logic [3:0]  be;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_req_stage #(.MAX_WAIT(MW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid),
    .exec_state_i (es),
    .wdata_i      (wdata),
    .squash_i     (squash),
    .dmem_req_o   (req),
    .dmem_we_o    (we),
    .dmem_addr_o  (addr),
    .dmem_be_o    (be),
    .dmem_wdata_o (bwdata),
    .dmem_gnt_i   (gnt),
    .dmem_rvalid_i(rvalid),
    .dmem_err_i   (err),
    .stall_o      (stall),
    .done_o       (done),
    .bus_err_o    (berr),
    .misalign_o   (misalign)
  );

  // Reference rules: a size-byte access enables size bytes starting at off,
  // and every lane carries byte (lane mod size) of the store operand.
  function automatic logic [3:0] exp_be(input int size, input int off);
    int v;
    v = ((1 << size) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input int size, input logic [31:0] d);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = d[8*(b % size) +: 8];
    return res;
  endfunction

  // Drives one access issued at cycle 0, gnt at cycle g, rvalid at cycle g+r.
  // sq: 0 none, 1 squash in the issue cycle, 2 squash one cycle after issue.
  task automatic drive_txn(input logic [1:0] width, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int g, input int r, input logic e,
                           input int sq,
                           output int n_req, output int n_stall, output int n_done,
                           output int n_berr, output int berr_at,
                           output logic [31:0] a0, output logic [3:0] be0,
                           output logic [31:0] wd0, output logic we0, output logic stable);
    n_req = 0; n_stall = 0; n_done = 0; n_berr = 0; berr_at = -1;
    a0 = '0; be0 = '0; wd0 = '0; we0 = 1'b0; stable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      valid        = (k == 0);
      es.alu_out   = a;
      es.mem_read  = ~wr;
      es.mem_write = wr;
      es.mem_width = mem_width_t'(width);
      wdata        = wd;
      squash       = (sq == 1 && k == 0) || (sq == 2 && k == 1);
      gnt          = (k == g);
      rvalid       = (k == g + r);
      err          = e && (k == g + r);
      @(negedge clk);
      if (req) begin
        if (n_req == 0) begin
          a0 = addr; be0 = be; wd0 = bwdata; we0 = we;
        end else if (addr !== a0 || be !== be0 || bwdata !== wd0 || we !== we0) begin
          stable = 1'b0;
        end
        n_req++;
      end
      if (stall) n_stall++;
      if (done) n_done++;
      if (berr) begin
        n_berr++;
        if (berr_at < 0) berr_at = k;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0; squash = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", req); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_checks++; if (done !== 1'b0 || berr !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got done=%b berr=%b exp=0", done, berr); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    n_checks++; if ({we, addr, be, bwdata} !== '0) begin n_fail++; $display("FAIL reset_bus got we=%b addr=%h be=%b wd=%h exp=0", we, addr, be, bwdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_lb_same_cycle;
    int nr, ns, nd, nb, ba; logic [31:0] a0, wd0; logic [3:0] be0; logic we0, st;
    drive_txn(2'd0, 1'b0, 32'h0000_0103, 32'h0, 0, 0, 1'b0, 0, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    $display("txn lb_same_cycle: addr=%h be=%b req=%0d stall=%0d done=%0d", a0, be0, nr, ns, nd);
    n_checks++; if (a0 !== 32'h0000_0100) begin n_fail++; $display("FAIL lb_addr got=%h exp=00000100", a0); end
    n_checks++; if (be0 !== 4'b1000) begin n_fail++; $display("FAIL lb_be got=%b exp=1000", be0); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL lb_done_cycles got=%0d exp=1", nd); end
    n_checks++; if (ns !== 0) begin n_fail++; $display("FAIL lb_stall_cycles got=%0d exp=0", ns); end
    n_checks++; if (nr !== 1) begin n_fail++; $display("FAIL lb_req_cycles got=%0d exp=1", nr); end
  endtask

  task automatic test_sw_delayed;
    int nr, ns, nd, nb, ba; logic [31:0] a0, wd0; logic [3:0] be0; logic we0, st;
    drive_txn(2'd2, 1'b1, 32'h0000_2040, 32'hDEAD_BEEF, 3, 2, 1'b0, 0, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    $display("txn sw_delayed: wd=%h req=%0d stall=%0d done=%0d stable=%b", wd0, nr, ns, nd, st);
    n_checks++; if (nr !== 4 || st !== 1'b1) begin n_fail++; $display("FAIL sw_req_stable got cycles=%0d stable=%b exp=4/1", nr, st); end
    n_checks++; if (ns !== 5) begin n_fail++; $display("FAIL sw_stall_cycles got=%0d exp=5", ns); end
    n_checks++; if (wd0 !== 32'hDEAD_BEEF || we0 !== 1'b1 || be0 !== 4'b1111) begin n_fail++; $display("FAIL sw_bus got wd=%h we=%b be=%b exp=deadbeef/1/1111", wd0, we0, be0); end
    n_checks++; if (nd !== 1 || nb !== 0) begin n_fail++; $display("FAIL sw_done got done=%0d berr=%0d exp=1/0", nd, nb); end
  endtask

  task automatic test_sh_off2;
    int nr, ns, nd, nb, ba; logic [31:0] a0, wd0; logic [3:0] be0; logic we0, st;
    drive_txn(2'd1, 1'b1, 32'h0000_3006, 32'h1234_ABCD, 1, 1, 1'b1, 0, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    $display("txn sh_off2: addr=%h be=%b wd=%h done=%0d berr=%0d", a0, be0, wd0, nd, nb);
    n_checks++; if (be0 !== 4'b1100) begin n_fail++; $display("FAIL sh_be got=%b exp=1100", be0); end
    n_checks++; if (wd0 !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata got=%h exp=abcdabcd", wd0); end
    n_checks++; if (a0 !== 32'h0000_3004) begin n_fail++; $display("FAIL sh_addr got=%h exp=00003004", a0); end
    n_checks++; if (nd !== 1 || nb !== 1) begin n_fail++; $display("FAIL sh_err_resp got done=%0d berr=%0d exp=1/1", nd, nb); end
  endtask

  task automatic test_timeout;
    int nr, ns, nd, nb, ba; logic [31:0] a0, wd0; logic [3:0] be0; logic we0, st;
    drive_txn(2'd2, 1'b0, 32'h0000_0400, 32'h0, 99, 0, 1'b0, 0, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    $display("txn timeout: req=%0d stall=%0d berr=%0d berr_at=%0d done=%0d", nr, ns, nb, ba, nd);
    n_checks++; if (nb !== 1 || ba !== MW) begin n_fail++; $display("FAIL timeout_berr got count=%0d at=%0d exp=1 at %0d", nb, ba, MW); end
    n_checks++; if (nr !== MW) begin n_fail++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", nr, MW); end
    n_checks++; if (ns !== MW || nd !== 0) begin n_fail++; $display("FAIL timeout_stall_done got stall=%0d done=%0d exp=%0d/0", ns, nd, MW); end
    drive_txn(2'd2, 1'b0, 32'h0000_0404, 32'h0, 0, 0, 1'b0, 0, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    $display("txn after_timeout: req=%0d stall=%0d done=%0d", nr, ns, nd);
    n_checks++; if (nr !== 1 || ns !== 0 || nd !== 1) begin n_fail++; $display("FAIL timeout_back_to_idle got req=%0d stall=%0d done=%0d exp=1/0/1", nr, ns, nd); end
  endtask

  task automatic test_reset_mid;
    valid = 1'b1; es.alu_out = 32'h0000_0040; es.mem_read = 1'b1; es.mem_write = 1'b0;
    es.mem_width = WORD; gnt = 1'b1; rvalid = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0; gnt = 1'b0;
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_stall got=%b exp=1", stall); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({req, stall, done, berr} !== 4'b0) begin n_fail++; $display("FAIL rstmid_ctrl got req=%b stall=%b done=%b berr=%b exp=0", req, stall, done, berr); end
    n_checks++; if ({we, addr, be, bwdata} !== '0) begin n_fail++; $display("FAIL rstmid_bus got addr=%h be=%b exp=0", addr, be); end
    @(posedge clk); #1;
    rst_n = 1'b1; rvalid = 1'b1;
    @(negedge clk);
    $display("txn reset_mid: late rvalid done=%b stall=%b", done, stall);
    n_checks++; if (done !== 1'b0 || stall !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_rvalid got done=%b stall=%b req=%b exp=0", done, stall, req); end
    @(posedge clk); #1;
    rvalid = 1'b0;
  endtask

  task automatic test_squash;
    int nr, ns, nd, nb, ba; logic [31:0] a0, wd0; logic [3:0] be0; logic we0, st;
    drive_txn(2'd0, 1'b1, 32'h0000_0011, 32'h55, 0, 0, 1'b0, 1, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    $display("txn squash_pre: req=%0d stall=%0d done=%0d", nr, ns, nd);
    n_checks++; if (nr !== 0 || ns !== 0 || nd !== 0 || nb !== 0) begin n_fail++; $display("FAIL squash_pre got req=%0d stall=%0d done=%0d berr=%0d exp=0", nr, ns, nd, nb); end
    drive_txn(2'd1, 1'b0, 32'h0000_0012, 32'h0, 2, 1, 1'b1, 2, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    $display("txn squash_post: req=%0d stall=%0d done=%0d berr=%0d", nr, ns, nd, nb);
    n_checks++; if (nr !== 3 || ns !== 3) begin n_fail++; $display("FAIL squash_post_completes got req=%0d stall=%0d exp=3/3", nr, ns); end
    n_checks++; if (nd !== 0 || nb !== 0) begin n_fail++; $display("FAIL squash_post_silent got done=%0d berr=%0d exp=0/0", nd, nb); end
  endtask

  task automatic test_misalign;
    int nr, ns, nd, nb, ba; logic [31:0] a0, wd0; logic [3:0] be0; logic we0, st;
`ifdef DMEM_MISALIGN_TRAP_EN
    valid = 1'b1; es.alu_out = 32'h0000_0102; es.mem_read = 1'b1; es.mem_write = 1'b0; es.mem_width = WORD;
    @(negedge clk);
    $display("txn lw_misaligned_trap: misalign=%b req=%b", misalign, req);
    n_checks++; if (misalign !== 1'b1 || req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL misalign_lw got mis=%b req=%b stall=%b exp=1/0/0", misalign, req, stall); end
    @(posedge clk); #1;
    es.alu_out = 32'h0000_0101; es.mem_width = HALF;
    @(negedge clk);
    n_checks++; if (misalign !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL misalign_lh got mis=%b req=%b exp=1/0", misalign, req); end
    @(posedge clk); #1;
    valid = 1'b0;
    drive_txn(2'd1, 1'b0, 32'h0000_0102, 32'h0, 0, 0, 1'b0, 0, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    n_checks++; if (nr !== 1 || be0 !== 4'b1100) begin n_fail++; $display("FAIL misalign_aligned_lh got req=%0d be=%b exp=1/1100", nr, be0); end
`else
    valid = 1'b1; squash = 1'b1; es.alu_out = 32'h0000_0102; es.mem_read = 1'b1; es.mem_write = 1'b0; es.mem_width = WORD;
    @(negedge clk);
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_flag got=%b exp=0", misalign); end
    @(posedge clk); #1;
    valid = 1'b0; squash = 1'b0;
    drive_txn(2'd2, 1'b0, 32'h0000_0102, 32'h0, 0, 0, 1'b0, 0, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    $display("txn lw_misaligned: addr=%h be=%b req=%0d", a0, be0, nr);
    n_checks++; if (nr !== 1 || a0 !== 32'h0000_0100 || be0 !== 4'b1111) begin n_fail++; $display("FAIL misalign_lw got req=%0d addr=%h be=%b exp=1/00000100/1111", nr, a0, be0); end
    drive_txn(2'd1, 1'b1, 32'h0000_0203, 32'h0000_BEEF, 0, 0, 1'b0, 0, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
    n_checks++; if (be0 !== exp_be(2, 0) || wd0 !== exp_wd(2, 32'h0000_BEEF)) begin n_fail++; $display("FAIL misalign_sh got be=%b wd=%h exp=0011/beefbeef", be0, wd0); end
`endif
  endtask

  task automatic test_random;
    int nr, ns, nd, nb, ba; logic [31:0] a0, wd0; logic [3:0] be0; logic we0, st;
    int width, size, off, g, r, sq, c;
    int e_req, e_stall, e_done, e_berr;
    logic wr, e;
    logic [31:0] a, d;
    for (int t = 0; t < 40; t++) begin
      width = $urandom_range(0, 2);
      size  = 1 << width;
      off   = ($urandom_range(0, 3) / size) * size;
      wr    = 1'($urandom_range(0, 1));
      a     = $urandom;
      a[1:0] = 2'(off);
      d     = $urandom;
      g     = $urandom_range(0, 4);
      r     = $urandom_range(0, 4);
      e     = 1'($urandom_range(0, 1));
      c     = g + r;
      sq    = $urandom_range(0, 7);
      sq    = (sq == 0) ? 1 : (sq == 1 && c >= 1) ? 2 : 0;
      drive_txn(2'(width), wr, a, d, g, r, e, sq, nr, ns, nd, nb, ba, a0, be0, wd0, we0, st);
      if (sq == 1) begin
        e_req = 0; e_stall = 0; e_done = 0; e_berr = 0;
      end else begin
        e_req = g + 1; e_stall = c;
        e_done = (sq == 2) ? 0 : 1;
        e_berr = (sq == 2) ? 0 : int'(e);
      end
      $display("txn rnd%0d: w=%0d wr=%b addr=%h g=%0d r=%0d sq=%0d req=%0d stall=%0d done=%0d berr=%0d",
               t, width, wr, a, g, r, sq, nr, ns, nd, nb);
      n_checks++; if (nr !== e_req || ns !== e_stall) begin n_fail++; $display("FAIL rnd%0d_timing got req=%0d stall=%0d exp=%0d/%0d", t, nr, ns, e_req, e_stall); end
      n_checks++; if (nd !== e_done || nb !== e_berr) begin n_fail++; $display("FAIL rnd%0d_pulses got done=%0d berr=%0d exp=%0d/%0d", t, nd, nb, e_done, e_berr); end
      if (e_req > 0) begin
        n_checks++;
        if (a0 !== {a[31:2], 2'b00} || be0 !== exp_be(size, off) || wd0 !== exp_wd(size, d) || we0 !== wr || st !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd%0d_bus got addr=%h be=%b wd=%h we=%b stable=%b exp=%h/%b/%h/%b/1",
                   t, a0, be0, wd0, we0, st, {a[31:2], 2'b00}, exp_be(size, off), exp_wd(size, d), wr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_same_cycle();
    test_sw_delayed();
    test_sh_off2();
    test_timeout();
    test_reset_mid();
    test_squash();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
